// File: rtl/alu32.sv
// alu32: registered 32-bit ALU built from one-bit slices on a ripple-carry
// chain. Results and the per-slice carry vector appear one cycle after the
// operands are sampled; a synchronous active-low reset clears both.
module alu32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OpCode,
  input  logic [WIDTH-1:0] CarryIn,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] CarryOut
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOR  = 3'd5,
    OP_SLT  = 3'd6,
    OP_NAND = 3'd7
  } op_e;

  op_e              op;
  logic             binv;
  logic             cin0;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] chain;
  logic             less;
  logic [WIDTH-1:0] out_d,   out_q;
  logic [WIDTH-1:0] carry_d, carry_q;

  // Only CarryIn[0] feeds the chain; the upper bits are intentionally ignored.
  logic unused_carry_in;
  assign unused_carry_in = ^CarryIn[WIDTH-1:1];

  assign op = op_e'(OpCode);

  // Slice-0 carry and B inversion: SUB and SLT both compute A + ~B + 1.
  always_comb begin
    binv = (op == OP_SUB) || (op == OP_SLT);
    cin0 = (op == OP_ADD) ? CarryIn[0] : binv;
  end

  // Ripple chain of one-bit full-adder slices; chain[i] is slice i carry-out.
  always_comb begin
    logic c;
    logic bb;
    sum   = '0;
    chain = '0;
    c     = cin0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bb       = B[i] ^ binv;
      sum[i]   = A[i] ^ bb ^ c;
      c        = (A[i] & bb) | (c & (A[i] ^ bb));
      chain[i] = c;
    end
  end

  // Signed less-than from the subtract: sign bit corrected by the overflow
  // (carry into MSB differs from carry out of MSB).
  always_comb begin
    less = sum[WIDTH-1] ^ (chain[WIDTH-1] ^ chain[WIDTH-2]);
  end

  // Result select; carry vector is only exposed for ADD and SUB.
  always_comb begin
    out_d   = '0;
    carry_d = '0;
    unique case (op)
      OP_AND:  out_d = A & B;
      OP_OR:   out_d = A | B;
      OP_ADD: begin
        out_d   = sum;
        carry_d = chain;
      end
      OP_SUB: begin
        out_d   = sum;
        carry_d = chain;
      end
      OP_XOR:  out_d = A ^ B;
      OP_NOR:  out_d = ~(A | B);
      OP_SLT:  out_d = {{(WIDTH-1){1'b0}}, less};
      OP_NAND: out_d = ~(A & B);
      default: out_d = '0;
    endcase
  end

  // Output registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= '0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign Output   = out_q;
  assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu32.sv
// tb_alu32: directed vectors with hand-computed expectations pushed into a
// scoreboard queue; a monitor pops and compares one cycle after each sample.
module tb_alu32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  OpCode;
  logic [31:0] CarryIn;
  logic [31:0] Output;
  logic [31:0] CarryOut;

  logic        tb_vld;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic [31:0] co;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks;
  int   passed;

  alu32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .OpCode   (OpCode),
    .CarryIn  (CarryIn),
    .Output   (Output),
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation on the falling edge and record what it should yield.
  task automatic issue(input string nm, input logic rst, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] ci, input logic [31:0] eo,
                       input logic [31:0] eco);
    exp_t x;
    @(negedge clk);
    rst_n   = rst;
    A       = a;
    B       = b;
    OpCode  = op;
    CarryIn = ci;
    tb_vld  = 1'b1;
    x.name  = nm;
    x.out   = eo;
    x.co    = eco;
    sb.push_back(x);
  endtask

  // Monitor: every edge that sampled a bench operation produces one result.
  always @(posedge clk) begin
    if (tb_vld) begin
      #1;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL sb_empty: output 0x%08h arrived with no expectation queued", Output);
      end else begin
        e = sb.pop_front();
        checks++;
        if (Output === e.out) passed++;
        else $display("FAIL %s.Output: got 0x%08h expected 0x%08h", e.name, Output, e.out);
        checks++;
        if (CarryOut === e.co) passed++;
        else $display("FAIL %s.CarryOut: got 0x%08h expected 0x%08h", e.name, CarryOut, e.co);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks  = 0;
    passed  = 0;
    tb_vld  = 1'b0;
    rst_n   = 1'b0;
    A       = '0;
    B       = '0;
    OpCode  = '0;
    CarryIn = '0;

    // Reset held over an ADD that would otherwise produce a nonzero result.
    issue("rst0",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 32'h0, 32'h0,         32'h0);
    issue("rst1",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 32'h0, 32'h0,         32'h0);
    issue("first",     1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

    // Arithmetic
    issue("add5_7",    1'b1, 32'd5,         32'd7,         3'd2, 32'h0, 32'd12,        32'h0000_0007);
    issue("addwrap",   1'b1, 32'hFFFF_FFFF, 32'd1,         3'd2, 32'h0, 32'h0,         32'hFFFF_FFFF);
    issue("addwrapci", 1'b1, 32'hFFFF_FFFF, 32'd1,         3'd2, 32'h1, 32'h1,         32'hFFFF_FFFF);
    issue("addcihi",   1'b1, 32'd1,         32'd1,         3'd2, 32'hFFFF_FFFE, 32'd2, 32'h0000_0001);
    issue("sub3_5",    1'b1, 32'd3,         32'd5,         3'd3, 32'h1, 32'hFFFF_FFFE, 32'h0000_0003);
    issue("sub5_3",    1'b1, 32'd5,         32'd3,         3'd3, 32'h0, 32'd2,         32'hFFFF_FFFD);

    // Logic ops
    issue("and",       1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0, 32'h1, 32'hF000_F000, 32'h0);
    issue("or",        1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd1, 32'h1, 32'hFFF0_FFF0, 32'h0);
    issue("xor",       1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 32'h1, 32'h0FF0_0FF0, 32'h0);
    issue("nor",       1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 32'h1, 32'h000F_000F, 32'h0);
    issue("nand",      1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 32'h1, 32'h0FFF_0FFF, 32'h0);

    // Signed compare, including the overflowing subtract case
    issue("slt_m1_1",  1'b1, 32'hFFFF_FFFF, 32'd1,         3'd6, 32'h0, 32'd1,         32'h0);
    issue("slt_1_m1",  1'b1, 32'd1,         32'hFFFF_FFFF, 3'd6, 32'h0, 32'd0,         32'h0);
    issue("slt_ovf",   1'b1, 32'h8000_0000, 32'd1,         3'd6, 32'h0, 32'd1,         32'h0);
    issue("slt_eq",    1'b1, 32'h1234_5678, 32'h1234_5678, 3'd6, 32'h0, 32'd0,         32'h0);

    // Mid-stream reset wins over an operation, then normal service resumes
    issue("rstmid",    1'b0, 32'd5,         32'd7,         3'd2, 32'h0, 32'h0,         32'h0);
    issue("afterrst",  1'b1, 32'd5,         32'd7,         3'd2, 32'h0, 32'd12,        32'h0000_0007);

    @(negedge clk);
    tb_vld = 1'b0;
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left in queue, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu32.md
ALU32 -- requirements
Module: alu32

Interface
REQ-001 Parameter WIDTH, default 32: operand, result and carry-vector width; all widths below are stated for WIDTH=32.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 Port A, input, 32: operand A.
REQ-005 Port B, input, 32: operand B.
REQ-006 Port OpCode, input, 3: operation select.
REQ-007 Port CarryIn, input, 32: carry input vector; only bit 0 is functional, bits 31:1 are ignored.
REQ-008 Port Output, output, 32: registered result.
REQ-009 Port CarryOut, output, 32: registered per-bit carry vector; bit i is the carry out of bit slice i.

Function
REQ-010 The ALU SHALL be built as 32 one-bit slices chained as a ripple carry; slice i carry-in is slice i-1 carry-out, and slice 0 carry-in is defined per opcode.
REQ-011 OpCode decode SHALL be:
- 0 AND: A & B.
- 1 OR: A | B.
- 2 ADD: A + B + CarryIn[0]; slice 0 carry-in = CarryIn[0].
- 3 SUB: A + ~B + 1; slice 0 carry-in = 1; CarryIn ignored.
- 4 XOR: A ^ B.
- 5 NOR: ~(A | B).
- 6 SLT: Output = {31'b0, signed(A) < signed(B)}.
- 7 NAND: ~(A & B).
REQ-012 For ADD and SUB, CarryOut SHALL hold the full ripple-chain carry vector; CarryOut[31] is the final carry; for SUB, CarryOut[31]=1 means no borrow (A >= B unsigned).
REQ-013 For opcodes 0, 1, 4, 5, 6 and 7, CarryOut SHALL be all zeros.
REQ-014 Arithmetic SHALL wrap modulo 2^32; overflow is not flagged separately.
REQ-015 SLT SHALL use the correct signed comparison, including when A-B overflows, e.g. A=0x80000000, B=1 gives 1.
REQ-016 Inputs SHALL be sampled on a rising clk edge with rst_n=1; Output and CarryOut SHALL reflect that operation after the edge, giving a latency of exactly 1 cycle.
REQ-017 Output and CarryOut SHALL be held constant between edges and SHALL update every cycle; there is no handshake or enable.
REQ-018 Results SHALL depend only on the current sample and carry no history between operations.

Reset
REQ-019 When rst_n=0 at a rising clk edge, Output SHALL become 0x00000000 and CarryOut SHALL become 0x00000000, regardless of other inputs.
REQ-020 Reset SHALL take priority over any operation in the same cycle.
REQ-021 The first valid result SHALL appear on the first edge with rst_n=1.
REQ-022 Output values before the first clk edge are don't-care.

Verification
REQ-023 Bench SHALL cover reset: rst_n=0 for 2 cycles with A=B=0xFFFFFFFF and Op=2 -> Output=0, CarryOut=0; after releasing reset and one edge -> Output=0xFFFFFFFE.
REQ-024 Bench SHALL cover ADD: A=5, B=7, Op=2, Ci=0 -> after 1 cycle Output=12, CarryOut=0x00000007.
REQ-025 Bench SHALL cover ADD wrap: A=0xFFFFFFFF, B=1, Op=2, Ci=0 -> Output=0, CarryOut=0xFFFFFFFF; the same with Ci=1 -> Output=1, CarryOut=0xFFFFFFFF.
REQ-026 Bench SHALL cover SUB: A=3, B=5, Op=3, Ci=1 (ignored) -> Output=0xFFFFFFFE, CarryOut=0x00000003.
REQ-027 Bench SHALL cover logic ops: A=0xF0F0F0F0, B=0xFF00FF00 -> Op0 gives 0xF000F000, Op1 gives 0xFFF0FFF0, Op4 gives 0x0FF00FF0, Op5 gives 0x000F000F, Op7 gives 0x0FFF0FFF; CarryOut=0 for all.
REQ-028 Bench SHALL cover SLT: A=0xFFFFFFFF, B=1, Op=6 -> Output=1; A=1, B=0xFFFFFFFF -> Output=0; A=0x80000000, B=1 -> Output=1; CarryOut=0 in all cases.
